// File: rtl/wb_cdb_arbiter_pkg.sv
// rtl/wb_cdb_arbiter_pkg.sv - shared widths, writeback source indices and round-robin helper
//
// Purpose: constants shared by the writeback CDB arbiter and its result FIFOs.
// Ports:   none (package).
package wb_cdb_arbiter_pkg;

   localparam int WORD_WIDTH    = 32;
   localparam int ROB_DEPTH     = 16;

   localparam int WB_SRC_ALU    = 0;
   localparam int WB_SRC_MUL    = 1;
   localparam int WB_SRC_DIV    = 2;
   localparam int WB_SRC_LOAD   = 3;
   localparam int WB_SRC_BR     = 4;

   localparam int WB_NUM_SRC    = 5;
   localparam int WB_NUM_CDB    = 2;
   localparam int WB_FIFO_DEPTH = 4;

   // Width of a source index as driven on cdb_src.
   localparam int WB_SRC_W      = 3;

   // (base + offset) mod num_src, valid while base < num_src and offset <= num_src.
   function automatic logic [WB_SRC_W-1:0] wb_rr_index(input logic [WB_SRC_W-1:0] base,
                                                      input int unsigned          offset,
                                                      input int unsigned          num_src);
      int unsigned sum;
      sum = 32'(base) + offset;
      if (sum >= num_src) begin
         sum = sum - num_src;
      end
      return WB_SRC_W'(sum);
   endfunction

endpackage

// File: rtl/wb_cdb_arbiter_fifo.sv
// rtl/wb_cdb_arbiter_fifo.sv - per-source result FIFO for the writeback CDB arbiter
//
// Purpose: synchronous FIFO holding {data, tag} results of one writeback source.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_flush          empties the FIFO; wins over push and pop
//   i_push, i_wdata  write request and entry
//   i_pop            remove the head entry
//   o_head           current head entry (valid while !o_empty)
//   o_count          number of stored entries
//   o_empty, o_full  occupancy flags
module wb_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];

   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// rtl/wb_cdb_arbiter.sv - round-robin sharing of the result buses among the writeback sources
//
// Purpose: buffers each writeback source in its own FIFO and grants up to NUM_CDB
//          FIFO heads per cycle onto registered result buses (ROB/PRF write, wakeup).
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_flush            discards all buffered results and in-flight bus values
//   i_src_valid/data/tag  per-source results, source i at slice i
//   o_src_ready        bit i set while FIFO i has at least 2 free entries
//   o_cdb_valid/data/tag/src  registered bus outputs, bus b at slice b
//   o_overflow_err     sticky: a result was dropped at a full FIFO
module wb_cdb_arbiter
   import wb_cdb_arbiter_pkg::*;
#(
   parameter int WORD_WIDTH = wb_cdb_arbiter_pkg::WORD_WIDTH,
   parameter int ROB_DEPTH  = wb_cdb_arbiter_pkg::ROB_DEPTH,
   parameter int NUM_SRC    = WB_NUM_SRC,
   parameter int NUM_CDB    = WB_NUM_CDB,
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
   parameter int TAG_W      = $clog2(ROB_DEPTH)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   input  logic [NUM_SRC-1:0]            i_src_valid,
   input  logic [NUM_SRC*WORD_WIDTH-1:0] i_src_data,
   input  logic [NUM_SRC*TAG_W-1:0]      i_src_tag,
   output logic [NUM_SRC-1:0]            o_src_ready,
   output logic [NUM_CDB-1:0]            o_cdb_valid,
   output logic [NUM_CDB*WORD_WIDTH-1:0] o_cdb_data,
   output logic [NUM_CDB*TAG_W-1:0]      o_cdb_tag,
   output logic [NUM_CDB*WB_SRC_W-1:0]   o_cdb_src,
   output logic                          o_overflow_err
);

   localparam int ENT_W = WORD_WIDTH + TAG_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [ENT_W-1:0]            w_head  [NUM_SRC];
   logic [CNT_W-1:0]            w_count [NUM_SRC];
   logic [NUM_SRC-1:0]          w_empty;
   logic [NUM_SRC-1:0]          w_full;
   logic [NUM_SRC-1:0]          w_pop;
   logic [NUM_SRC-1:0]          w_drop;
   logic [NUM_CDB-1:0]          w_grant_vld;
   logic [WB_SRC_W-1:0]         w_grant_idx [NUM_CDB];
   logic [WB_SRC_W-1:0]         w_next_ptr;

   logic [WB_SRC_W-1:0]         r_rr_ptr;
   logic [NUM_CDB-1:0]          r_cdb_valid;
   logic [NUM_CDB*WORD_WIDTH-1:0] r_cdb_data;
   logic [NUM_CDB*TAG_W-1:0]    r_cdb_tag;
   logic [NUM_CDB*WB_SRC_W-1:0] r_cdb_src;
   logic                        r_overflow;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      wb_fifo #(
         .WIDTH (ENT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_flush (i_flush),
         .i_push  (i_src_valid[g]),
         .i_wdata ({i_src_data[g*WORD_WIDTH +: WORD_WIDTH], i_src_tag[g*TAG_W +: TAG_W]}),
         .i_pop   (w_pop[g]),
         .o_head  (w_head[g]),
         .o_count (w_count[g]),
         .o_empty (w_empty[g]),
         .o_full  (w_full[g])
      );

      // Based on the registered count, so one result already in flight still fits.
      assign o_src_ready[g] = (CNT_W'(FIFO_DEPTH) - w_count[g]) >= CNT_W'(2);
      // Flushed inputs are discarded deliberately and do not count as overflow.
      assign w_drop[g] = i_src_valid[g] && w_full[g] && !w_pop[g] && !i_flush;
   end

   // Scan from r_rr_ptr; the n-th non-empty source found drives bus n.
   always_comb begin : arb
      logic [WB_SRC_W-1:0] idx;
      int                  rank;
      w_pop       = '0;
      w_grant_vld = '0;
      w_next_ptr  = r_rr_ptr;
      idx         = '0;
      rank        = 0;
      for (int b = 0; b < NUM_CDB; b++) begin
         w_grant_idx[b] = '0;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = wb_rr_index(r_rr_ptr, k, NUM_SRC);
         if (!w_empty[idx] && rank < NUM_CDB) begin
            for (int b = 0; b < NUM_CDB; b++) begin
               if (rank == b) begin
                  w_grant_vld[b] = 1'b1;
                  w_grant_idx[b] = idx;
               end
            end
            w_pop[idx] = 1'b1;
            w_next_ptr = wb_rr_index(idx, 1, NUM_SRC);
            rank       = rank + 1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr    <= '0;
         r_cdb_valid <= '0;
         r_cdb_data  <= '0;
         r_cdb_tag   <= '0;
         r_cdb_src   <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_overflow <= r_overflow | (|w_drop);
         if (i_flush) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= '0;
         end else begin
            r_rr_ptr    <= w_next_ptr;
            r_cdb_valid <= w_grant_vld;
            // Ungranted buses keep their last payload; only valid drops.
            for (int b = 0; b < NUM_CDB; b++) begin
               if (w_grant_vld[b]) begin
                  r_cdb_data[b*WORD_WIDTH +: WORD_WIDTH] <= w_head[w_grant_idx[b]][ENT_W-1:TAG_W];
                  r_cdb_tag[b*TAG_W +: TAG_W]            <= w_head[w_grant_idx[b]][TAG_W-1:0];
                  r_cdb_src[b*WB_SRC_W +: WB_SRC_W]      <= w_grant_idx[b];
               end
            end
         end
      end
   end

   assign o_cdb_valid    = r_cdb_valid;
   assign o_cdb_data     = r_cdb_data;
   assign o_cdb_tag      = r_cdb_tag;
   assign o_cdb_src      = r_cdb_src;
   assign o_overflow_err = r_overflow;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// tb/tb_wb_cdb_arbiter.sv - self-checking bench for wb_cdb_arbiter
module tb_wb_cdb_arbiter;

   localparam int NS = 5;
   localparam int NC = 2;
   localparam int WW = 32;
   localparam int TW = 4;
   localparam int FD = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic [NS-1:0]     src_valid = '0;
   logic [NS*WW-1:0]  src_data = '0;
   logic [NS*TW-1:0]  src_tag = '0;
   logic [NS-1:0]     src_ready;
   logic [NC-1:0]     cdb_valid;
   logic [NC*WW-1:0]  cdb_data;
   logic [NC*TW-1:0]  cdb_tag;
   logic [NC*3-1:0]   cdb_src;
   logic              ovf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_cdb_arbiter dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_flush        (flush),
      .i_src_valid    (src_valid),
      .i_src_data     (src_data),
      .i_src_tag      (src_tag),
      .o_src_ready    (src_ready),
      .o_cdb_valid    (cdb_valid),
      .o_cdb_data     (cdb_data),
      .o_cdb_tag      (cdb_tag),
      .o_cdb_src      (cdb_src),
      .o_overflow_err (ovf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one queue per source, buses filled in scan order.
   logic [WW+TW-1:0] mq [NS][$];
   int               m_ptr;
   logic [NC-1:0]    m_valid;
   logic [WW-1:0]    m_data [NC];
   logic [TW-1:0]    m_tag  [NC];
   int               m_src  [NC];
   logic             m_ovf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NS; s++) mq[s].delete();
         m_ptr = 0; m_valid = '0; m_ovf = 1'b0;
         for (int b = 0; b < NC; b++) begin
            m_data[b] = '0; m_tag[b] = '0; m_src[b] = 0;
         end
      end else if (flush) begin
         for (int s = 0; s < NS; s++) mq[s].delete();
         m_ptr = 0; m_valid = '0;
      end else begin : step
         int nb;
         int last;
         int pre;
         bit popped [NS];
         nb = 0; last = 0; m_valid = '0;
         for (int s = 0; s < NS; s++) popped[s] = 1'b0;
         for (int k = 0; k < NS; k++) begin
            int s;
            s = (m_ptr + k) % NS;
            if (mq[s].size() != 0 && nb < NC) begin
               m_valid[nb] = 1'b1;
               {m_data[nb], m_tag[nb]} = mq[s][0];
               m_src[nb] = s;
               popped[s] = 1'b1;
               last = s;
               nb++;
            end
         end
         for (int s = 0; s < NS; s++) begin
            pre = mq[s].size();
            if (popped[s]) void'(mq[s].pop_front());
            if (src_valid[s]) begin
               if (pre < FD || popped[s]) mq[s].push_back({src_data[s*WW +: WW], src_tag[s*TW +: TW]});
               else m_ovf = 1'b1;
            end
         end
         if (nb > 0) m_ptr = (last + 1) % NS;
      end
   end

   logic watch = 1'b0;
   logic leaked = 1'b0;

   always @(negedge clk) begin
      chk("cdb_valid", cdb_valid, m_valid);
      for (int b = 0; b < NC; b++) begin
         chk("cdb_data", cdb_data[b*WW +: WW], m_data[b]);
         chk("cdb_tag", cdb_tag[b*TW +: TW], m_tag[b]);
         chk("cdb_src", cdb_src[b*3 +: 3], m_src[b]);
         if (watch && cdb_valid[b] && cdb_data[b*WW +: WW] == 32'hDEAD_BEEF) leaked = 1'b1;
      end
      for (int s = 0; s < NS; s++) chk("src_ready", src_ready[s], mq[s].size() <= FD - 2);
      chk("overflow_err", ovf, m_ovf);
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      src_valid = '0; flush = 1'b0;
   endtask

   task automatic put(input int s, input logic [WW-1:0] d, input logic [TW-1:0] t);
      src_valid[s] = 1'b1;
      src_data[s*WW +: WW] = d;
      src_tag[s*TW +: TW] = t;
   endtask

   task automatic do_reset();
      idle();
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", cdb_valid, 2'b00);
      chk("rst_ready", src_ready, 5'b11111);
      chk("rst_ovf", ovf, 1'b0);
      @(posedge clk); #3 rst = 1'b0;
      cyc();
   endtask

   logic saw_not_ready;

   initial begin
      do_reset();
      chk("rst_data", cdb_data, 64'h0);

      // Single ALU result, two-edge latency.
      put(0, 32'h1234_5678, 4'd3); cyc(); idle(); cyc();
      chk("t1_valid", cdb_valid, 2'b01);
      chk("t1_data", cdb_data[31:0], 32'h1234_5678);
      chk("t1_tag", cdb_tag[3:0], 4'd3);
      chk("t1_src", cdb_src[2:0], 3'd0);
      cyc();
      chk("t1_idle_valid", cdb_valid, 2'b00);
      chk("t1_idle_hold", cdb_data[31:0], 32'h1234_5678);

      // All five sources at once from pointer 0.
      do_reset();
      for (int s = 0; s < NS; s++) put(s, 32'hA0 + s, 4'(s + 1));
      cyc(); idle(); cyc();
      chk("t2_c1_valid", cdb_valid, 2'b11);
      chk("t2_c1_src", cdb_src, 6'b001_000);
      chk("t2_c1_data", cdb_data, {32'hA1, 32'hA0});
      cyc();
      chk("t2_c2_valid", cdb_valid, 2'b11);
      chk("t2_c2_src", cdb_src, 6'b011_010);
      cyc();
      chk("t2_c3_valid", cdb_valid, 2'b01);
      chk("t2_c3_src", cdb_src[2:0], 3'd4);
      cyc();
      chk("t2_c4_valid", cdb_valid, 2'b00);
      put(1, 32'hB1, 4'd1); put(0, 32'hB0, 4'd0); cyc(); idle(); cyc();
      chk("t2_ptr0", cdb_src, 6'b001_000);

      // Pointer wrap: reach 4, grant source 0, pointer becomes 1.
      put(3, 32'hC3, 4'd3); cyc(); idle(); cyc();
      chk("wrap_src3", cdb_src[2:0], 3'd3);
      put(0, 32'hC0, 4'd0); cyc(); idle(); cyc();
      chk("wrap_src0", cdb_src[2:0], 3'd0);
      put(0, 32'hD0, 4'd0); put(1, 32'hD1, 4'd1); cyc(); idle(); cyc();
      chk("wrap_order", cdb_src, 6'b000_001);
      chk("wrap_data", cdb_data, {32'hD0, 32'hD1});

      // All sources issuing while obeying ready: no overflow.
      do_reset();
      saw_not_ready = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (src_ready != 5'b11111) saw_not_ready = 1'b1;
         for (int s = 0; s < NS; s++) begin
            if (src_ready[s]) put(s, {8'(s), 24'(i)}, 4'(i));
            else src_valid[s] = 1'b0;
         end
         cyc();
      end
      idle();
      repeat (12) cyc();
      chk("t3_throttled", saw_not_ready, 1'b1);
      chk("t3_no_ovf", ovf, 1'b0);

      // Ignoring ready with every source busy forces drops.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         for (int s = 0; s < NS; s++) put(s, {8'(s + 16), 24'(i)}, 4'(s));
         cyc();
      end
      idle(); cyc();
      chk("t4_ovf_set", ovf, 1'b1);
      repeat (20) cyc();
      chk("t4_ovf_sticky", ovf, 1'b1);

      // Flush with a same-cycle push.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         for (int s = 1; s < NS; s++) put(s, {8'(s + 32), 24'(i)}, 4'(s));
         cyc();
      end
      idle();
      put(0, 32'hDEAD_BEEF, 4'd7); flush = 1'b1; watch = 1'b1;
      cyc(); idle();
      chk("t5_valid", cdb_valid, 2'b00);
      chk("t5_ready", src_ready, 5'b11111);
      repeat (5) cyc();
      chk("t5_no_leak", leaked, 1'b0);
      chk("t5_ovf", ovf, 1'b0);
      watch = 1'b0;

      // Asynchronous reset while buses are busy.
      for (int s = 0; s < NS; s++) put(s, 32'hE0 + s, 4'(s));
      cyc(); idle(); cyc();
      chk("t6_busy", |cdb_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_valid", cdb_valid, 2'b00);
      chk("t6_ready", src_ready, 5'b11111);
      @(posedge clk); #3 rst = 1'b0;
      cyc(); cyc();
      chk("t6_empty", cdb_valid, 2'b00);
      put(1, 32'hF1, 4'd1); put(0, 32'hF0, 4'd0); cyc(); idle(); cyc();
      chk("t6_ptr0", cdb_src, 6'b001_000);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
